// File: rtl/mult16_seq_ctrl.sv
// mult16_seq_ctrl
// Signed 16x16 multiply sequenced over four cycles of one shared, purely
// combinational 8x8 unsigned multiplier (mult8x8, outside this block).
// Operand magnitudes are registered at acceptance. The four partial products
// are accumulated in the order lo*lo, lo*hi, hi*lo, hi*hi. The sign is
// applied in a final cycle. The result is returned over a valid/ready
// handshake, and only one transaction is in flight at a time.
//
// Optional feature: define MULT16_SEQ_ZERO_SKIP_EN to route an operand pair
// containing a zero straight from IDLE to DONE with a zero result. When the
// feature is enabled, that path has a latency of one cycle and the shared
// multiplier is left untouched.
module mult16_seq_ctrl #(
   parameter int DW = 16
) (
   input  logic              nvdla_core_clk,
   input  logic              nvdla_core_rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DW-1:0]     in_a,
   input  logic [DW-1:0]     in_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2*DW-1:0]   out_data,
   output logic [DW/2-1:0]   mul_a,
   output logic [DW/2-1:0]   mul_b,
   input  logic [DW-1:0]     mul_p,
   output logic              busy
);

   localparam int HW = DW / 2;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_PP   = 2'd1;
   localparam logic [1:0] S_SIGN = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]      state;
   logic [1:0]      pp_cnt;
   logic [DW-1:0]   mag_a;
   logic [DW-1:0]   mag_b;
   logic            sign;
   logic [2*DW-1:0] acc;

   logic [DW-1:0]   abs_a;
   logic [DW-1:0]   abs_b;
   logic [4:0]      pp_shift;
   logic [2*DW-1:0] pp_shifted;
   logic            accept;
   logic            zero_skip;

   // Magnitudes of the incoming operands; the most negative value maps to
   // its own bit pattern, which is the correct unsigned magnitude.
   assign abs_a  = in_a[DW-1] ? (~in_a + 1'b1) : in_a;
   assign abs_b  = in_b[DW-1] ? (~in_b + 1'b1) : in_b;
   assign accept = in_valid && in_ready;

`ifdef MULT16_SEQ_ZERO_SKIP_EN
   assign zero_skip = (in_a == '0) || (in_b == '0);
`else
   assign zero_skip = 1'b0;
`endif

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign busy      = (state != S_IDLE);

   // Select the operand halves and shift for the current partial product;
   // the multiplier inputs stay at zero outside PP.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
      mul_a    = '0;
      mul_b    = '0;
      pp_shift = 5'd0;
      if (state == S_PP) begin
         case (pp_cnt)
            2'd0: begin
               mul_a    = mag_a[HW-1:0];
               mul_b    = mag_b[HW-1:0];
               pp_shift = 5'd0;
            end
            2'd1: begin
               mul_a    = mag_a[HW-1:0];
               mul_b    = mag_b[DW-1:HW];
               pp_shift = 5'd8;
            end
            2'd2: begin
               mul_a    = mag_a[DW-1:HW];
               mul_b    = mag_b[HW-1:0];
               pp_shift = 5'd8;
            end
            default: begin
               mul_a    = mag_a[DW-1:HW];
               mul_b    = mag_b[DW-1:HW];
               pp_shift = 5'd16;
            end
         endcase
      end
   end

   assign pp_shifted = {{DW{1'b0}}, mul_p} << pp_shift;

   // Sequencer: accept the operands, accumulate four partial products,
   // apply the sign, then hold the result until the consumer takes it.
   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         state    <= S_IDLE;
         pp_cnt   <= 2'd0;
         mag_a    <= '0;
         mag_b    <= '0;
         sign     <= 1'b0;
         acc      <= '0;
         out_data <= '0;
      end else begin
         // NOTE: state is updated with non-blocking assignments, so each register reads the values from before the edge.
         case (state)
            S_IDLE: begin
               if (accept) begin
                  mag_a  <= abs_a;
                  mag_b  <= abs_b;
                  sign   <= in_a[DW-1] ^ in_b[DW-1];
                  acc    <= '0;
                  pp_cnt <= 2'd0;
                  if (zero_skip) begin
                     out_data <= '0;
                     state    <= S_DONE;
                  end else begin
                     state    <= S_PP;
                  end
               end
            end
            S_PP: begin
               acc    <= acc + pp_shifted;
               pp_cnt <= pp_cnt + 2'd1;
               if (pp_cnt == 2'd3) begin
                  state <= S_SIGN;
               end
            end
            S_SIGN: begin
               out_data <= sign ? (~acc + 1'b1) : acc;
               state    <= S_DONE;
            end
            default: begin
               if (out_ready) begin
                  state <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult16_seq_ctrl.sv
// tb_mult16_seq_ctrl
// Self-checking bench for mult16_seq_ctrl. The shared 8x8 multiplier is
// modelled combinationally. Every expected product is computed with plain
// signed arithmetic. The bench follows MULT16_SEQ_ZERO_SKIP_EN when that
// macro is defined for the build.
module tb_mult16_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_a = '0;
   logic [15:0] in_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [7:0]  mul_a;
   logic [7:0]  mul_b;
   logic [15:0] mul_p;
   logic        busy;

   int errors = 0;
   int checks = 0;

   // Multiplier activity seen during the last transaction, one entry per cycle.
   logic [7:0] obs_a [0:15];
   logic [7:0] obs_b [0:15];
   int         obs_n;

`ifdef MULT16_SEQ_ZERO_SKIP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   mult16_seq_ctrl #(.DW(16)) dut (
      .nvdla_core_clk (clk),
      .nvdla_core_rst (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_a           (in_a),
      .in_b           (in_b),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .mul_a          (mul_a),
      .mul_b          (mul_b),
      .mul_p          (mul_p),
      .busy           (busy)
   );

   assign mul_p = mul_a * mul_b;

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_product(input logic [15:0] a, input logic [15:0] b);
      longint p;
      p = longint'($signed(a)) * longint'($signed(b));
      return p[31:0];
   endfunction

   // Runs one transaction. The consumer then stalls for hold cycles and
   // pulses in_valid while stalled. The result, latency, stability and the
   // release timing are all checked.
   task automatic run_txn(input logic [15:0] a, input logic [15:0] b,
                          input int hold, input string tag);
      logic [31:0] exp;
      int          lat;
      int          exp_lat;
      exp     = ref_product(a, b);
      exp_lat = (SKIP && (a == 16'h0 || b == 16'h0)) ? 0 : 5;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_before: in_ready=%b want 1", tag, in_ready);
      end
      in_a      = a;
      in_b      = b;
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_a     = 16'hDEAD;
      in_b     = 16'hBEEF;
      obs_n = 0;
      lat   = 0;
      obs_a[obs_n] = mul_a; obs_b[obs_n] = mul_b; obs_n++;
      while (out_valid !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (obs_n < 16) begin
            obs_a[obs_n] = mul_a; obs_b[obs_n] = mul_b; obs_n++;
         end
      end
      checks++;
      if (lat !== exp_lat) begin
         errors++;
         $display("FAIL %s latency: got %0d edges after accept, want %0d", tag, lat, exp_lat);
      end
      checks++;
      if (out_data !== exp) begin
         errors++;
         $display("FAIL %s out_data: got %h want %h (a=%h b=%h)", tag, out_data, exp, a, b);
      end
      for (int i = 0; i < hold; i++) begin
         in_valid = (i % 2 == 0);
         in_a     = 16'h0101 + 16'(i);
         in_b     = 16'h0202;
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s stall%0d: valid=%b data=%h ready=%b busy=%b want 1 %h 0 1",
                     tag, i, out_valid, out_data, in_ready, busy, exp);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s release: ready=%b valid=%b busy=%b want 1 0 0",
                  tag, in_ready, out_valid, busy);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0 ||
          busy !== 1'b0 || mul_a !== 8'h0 || mul_b !== 8'h0) begin
         errors++;
         $display("FAIL %s: ready=%b valid=%b data=%h busy=%b mul=%h,%h want 1 0 00000000 0 00,00",
                  tag, in_ready, out_valid, out_data, busy, mul_a, mul_b);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #12;
      check_idle_outputs("reset_values");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check_idle_outputs("after_reset_release");
   endtask

   task automatic test_basic();
      logic [7:0] ea [0:3];
      logic [7:0] eb [0:3];
      ea = '{8'h03, 8'h03, 8'h00, 8'h00};
      eb = '{8'h05, 8'h00, 8'h05, 8'h00};
      run_txn(16'h0003, 16'h0005, 0, "basic_3x5");
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (obs_a[i] !== ea[i] || obs_b[i] !== eb[i]) begin
            errors++;
            $display("FAIL basic_mul_seq%0d: got (%h,%h) want (%h,%h)",
                     i, obs_a[i], obs_b[i], ea[i], eb[i]);
         end
      end
      checks++;
      if (obs_a[4] !== 8'h00 || obs_b[4] !== 8'h00) begin
         errors++;
         $display("FAIL basic_mul_sign_idle: got (%h,%h) want (00,00)", obs_a[4], obs_b[4]);
      end
   endtask

   task automatic test_corners();
      run_txn(16'hFFFE, 16'h0003, 0, "neg2x3");
      run_txn(16'h8000, 16'h8000, 0, "min_x_min");
      run_txn(16'h7FFF, 16'h8000, 0, "max_x_min");
      run_txn(16'h8000, 16'h0000, 0, "min_x_zero");
      run_txn(16'hFFFF, 16'hFFFF, 0, "neg1_x_neg1");
   endtask

   task automatic test_zero();
      bit active;
      run_txn(16'h1234, 16'h0000, 0, "zero_b");
      active = 1'b0;
      for (int i = 0; i < obs_n; i++) begin
         if (SKIP && (obs_a[i] != 8'h0 || obs_b[i] != 8'h0)) active = 1'b1;
      end
      checks++;
      if (active !== 1'b0) begin
         errors++;
         $display("FAIL zero_skip_mul_idle: multiplier active=%b want 0", active);
      end
      run_txn(16'h0000, 16'hABCD, 1, "zero_a");
   endtask

   task automatic test_backpressure();
      run_txn(16'h1357, 16'hF00D, 10, "backpressure");
   endtask

   task automatic test_reset_mid();
      in_a     = 16'h1234;
      in_b     = 16'h5678;
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (mul_a !== 8'h12 || mul_b !== 8'h78 || busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_pp2_operands: mul=(%h,%h) busy=%b want (12,78) 1", mul_a, mul_b, busy);
      end
      rst = 1'b1;
      #1;
      check_idle_outputs("mid_reset_async");
      #2;
      rst = 1'b0;
      @(posedge clk); #1;
      check_idle_outputs("mid_reset_idle");
      run_txn(16'hC001, 16'h00FF, 0, "after_mid_reset");
   endtask

   task automatic test_random();
      logic [15:0] a;
      logic [15:0] b;
      for (int n = 0; n < 12; n++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         if ($urandom_range(0, 5) == 0) a = 16'h8000;
         if ($urandom_range(0, 7) == 0) b = 16'h0000;
         run_txn(a, b, int'($urandom_range(0, 3)), $sformatf("rand%0d", n));
      end
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 4; n++) begin
         run_txn(16'(16'h0F0F * (n + 1)), 16'(16'hFFF0 - 16'(n)), 0, $sformatf("b2b%0d", n));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_corners();
      test_zero();
      test_backpressure();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
